// File: rtl/ir_nec_pkg.sv
// Shared NEC IR protocol definitions: FSM states, per-state durations in NEC units.
// Used by both the transmitter and the receiver so their timing stays in lockstep.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_MARK,
        START_SPACE,
        BIT_MARK,
        BIT_SPACE,
        STOP_MARK
    } nec_state_t;

    localparam int UNIT_CNT_W = 5;

    localparam logic [UNIT_CNT_W-1:0] START_MARK_UNITS   = 5'd16;
    localparam logic [UNIT_CNT_W-1:0] START_SPACE_UNITS  = 5'd8;
    localparam logic [UNIT_CNT_W-1:0] REPEAT_SPACE_UNITS = 5'd4;
    localparam logic [UNIT_CNT_W-1:0] BIT_MARK_UNITS     = 5'd1;
    localparam logic [UNIT_CNT_W-1:0] ZERO_SPACE_UNITS   = 5'd1;
    localparam logic [UNIT_CNT_W-1:0] ONE_SPACE_UNITS    = 5'd3;
    localparam logic [UNIT_CNT_W-1:0] STOP_MARK_UNITS    = 5'd1;

    // Length of a state in NEC units; the bit space depends on the bit being sent.
    function automatic logic [UNIT_CNT_W-1:0] state_units(input nec_state_t st,
                                                          input logic rpt,
                                                          input logic bit_val);
        logic [UNIT_CNT_W-1:0] u;
        case (st)
            START_MARK:  u = START_MARK_UNITS;
            START_SPACE: u = rpt ? REPEAT_SPACE_UNITS : START_SPACE_UNITS;
            BIT_MARK:    u = BIT_MARK_UNITS;
            BIT_SPACE:   u = bit_val ? ONE_SPACE_UNITS : ZERO_SPACE_UNITS;
            STOP_MARK:   u = STOP_MARK_UNITS;
            default:     u = 5'd1;
        endcase
        return u;
    endfunction

    function automatic logic is_mark(input nec_state_t st);
        return (st == START_MARK) || (st == BIT_MARK) || (st == STOP_MARK);
    endfunction

endpackage

// File: rtl/ir_unit_timer.sv
// Unit prescaler: pulses unit_tick_o on the last cycle of every UNIT_TICKS-cycle unit.
// clr_i restarts the unit so each new state begins on a fresh unit boundary.
module ir_unit_timer #(
    parameter int UNIT_TICKS    = 562,
    parameter int COUNTER_WIDTH = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    output logic unit_tick_o
);

    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;

    assign unit_tick_o = (cnt_q == COUNTER_WIDTH'(UNIT_TICKS - 1));

    always_comb begin
        cnt_d = cnt_q + COUNTER_WIDTH'(1);
        if (clr_i || unit_tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR frame generator: serialises address/~address/data/~data (LSB first) or a repeat
// frame into an active-low mark/space waveform; all outputs registered, send ignored while busy.
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int UNIT_TICKS    = 562,
    parameter int COUNTER_WIDTH = 16,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [ADDRESS_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0]    data,
    input  logic                     send,
    input  logic                     repeat_code,
    output logic                     IR,
    output logic                     busy,
    output logic                     done
);

    localparam int TOTAL_BITS = 2 * (ADDRESS_WIDTH + DATA_WIDTH);
    localparam int BIT_CNT_W  = $clog2(TOTAL_BITS);

    nec_state_t                  state_q, state_d;
    logic [TOTAL_BITS-1:0]       shift_q, shift_d;
    logic                        rpt_q, rpt_d;
    logic [BIT_CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
    logic [UNIT_CNT_W-1:0]       unit_cnt_q, unit_cnt_d;
    logic                        ir_q, ir_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic [UNIT_CNT_W-1:0]       units;
    logic                        unit_tick;
    logic                        state_end;
    logic                        timer_clr;

    ir_unit_timer #(
        .UNIT_TICKS    (UNIT_TICKS),
        .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_timer (
        .clk_i       (CLK),
        .rst_i       (RST),
        .clr_i       (timer_clr),
        .unit_tick_o (unit_tick)
    );

    assign units     = state_units(state_q, rpt_q, shift_q[0]);
    assign state_end = unit_tick && (unit_cnt_q == units - UNIT_CNT_W'(1));
    assign timer_clr = (state_d != state_q) || (state_q == IDLE);

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        rpt_d      = rpt_q;
        bit_cnt_d  = bit_cnt_q;
        unit_cnt_d = unit_cnt_q;
        done_d     = 1'b0;

        if (unit_tick) begin
            unit_cnt_d = unit_cnt_q + UNIT_CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (send) begin
                    state_d   = START_MARK;
                    shift_d   = {~data, data, ~address, address};
                    rpt_d     = repeat_code;
                    bit_cnt_d = '0;
                end
            end
            START_MARK: begin
                if (state_end) state_d = START_SPACE;
            end
            START_SPACE: begin
                if (state_end) state_d = rpt_q ? STOP_MARK : BIT_MARK;
            end
            BIT_MARK: begin
                if (state_end) state_d = BIT_SPACE;
            end
            BIT_SPACE: begin
                if (state_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_CNT_W'(TOTAL_BITS - 1)) begin
                        state_d = STOP_MARK;
                    end else begin
                        state_d   = BIT_MARK;
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            STOP_MARK: begin
                if (state_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Unit count is per-state; a back-to-back state starts again at zero.
        if (state_d != state_q) begin
            unit_cnt_d = '0;
        end

        ir_d   = ~is_mark(state_d);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            rpt_q      <= 1'b0;
            bit_cnt_q  <= '0;
            unit_cnt_q <= '0;
            ir_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            rpt_q      <= rpt_d;
            bit_cnt_q  <= bit_cnt_d;
            unit_cnt_q <= unit_cnt_d;
            ir_q       <= ir_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign IR   = ir_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Bench for ir_nec_tx at UNIT_TICKS=4: frames are measured as IR run-lengths while busy
// and compared against expected segments queued when each send is driven.
module tb_ir_nec_tx;

    localparam int U = 4;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] address = 8'h00;
    logic [7:0] data = 8'h00;
    logic       send = 1'b0;
    logic       repeat_code = 1'b0;
    logic       IR, busy, done;

    ir_nec_tx #(
        .UNIT_TICKS    (U),
        .COUNTER_WIDTH (16),
        .ADDRESS_WIDTH (8),
        .DATA_WIDTH    (8)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .address     (address),
        .data        (data),
        .send        (send),
        .repeat_code (repeat_code),
        .IR          (IR),
        .busy        (busy),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: flat list of expected run-lengths plus per-frame segment count/length.
    int exp_segs_q[$];
    int exp_nseg_q[$];
    int exp_len_q[$];
    int frames_expected = 0;

    task automatic push_frame(input logic [7:0] a, input logic [7:0] d, input logic rpt);
        logic [31:0] bits;
        int segs[$];
        int len = 0;
        bits = {~d, d, ~a, a};
        segs.push_back(16 * U);
        segs.push_back((rpt ? 4 : 8) * U);
        if (!rpt) begin
            for (int i = 0; i < 32; i++) begin
                segs.push_back(U);
                segs.push_back((bits[i] ? 3 : 1) * U);
            end
        end
        segs.push_back(U);
        foreach (segs[i]) begin
            exp_segs_q.push_back(segs[i]);
            len += segs[i];
        end
        exp_nseg_q.push_back(segs.size());
        exp_len_q.push_back(len);
        frames_expected++;
    endtask

    task automatic drop_frame();
        int n;
        n = exp_nseg_q.pop_front();
        void'(exp_len_q.pop_front());
        for (int i = 0; i < n; i++) void'(exp_segs_q.pop_front());
        frames_expected--;
    endtask

    // Monitor
    bit   mon_en = 1'b0;
    logic prev_busy = 1'b0;
    int   seg_q[$];
    int   run = 0;
    logic cur_lvl = 1'b1;
    int   blen = 0;
    int   last_blen = 0;
    int   done_cnt = 0;

    always @(negedge CLK) begin
        if (!mon_en) begin
            prev_busy = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (prev_busy && busy === 1'b0) begin
                int n, bad;
                seg_q.push_back(run);
                last_blen = blen;
                chk("end_done_pulse", int'(done), 1);
                chk("end_ir_idle", int'(IR), 1);
                if (exp_len_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    chk("busy_len", blen, exp_len_q.pop_front());
                    n = exp_nseg_q.pop_front();
                    bad = -1;
                    for (int i = 0; i < n; i++) begin
                        int e;
                        e = exp_segs_q.pop_front();
                        if (bad < 0 && (i >= seg_q.size() || seg_q[i] != e)) bad = i;
                    end
                    if (bad < 0 && seg_q.size() != n) bad = n;
                    chk("waveform_first_bad_segment", bad, -1);
                end
            end else if (done === 1'b1) begin
                chk("done_stray", 1, 0);
            end
            if (busy === 1'b1 && !prev_busy) begin
                chk("start_ir_low", int'(IR), 0);
                seg_q.delete();
                cur_lvl = IR;
                run = 1;
                blen = 1;
            end else if (busy === 1'b1) begin
                blen++;
                if (IR == cur_lvl) begin
                    run++;
                end else begin
                    seg_q.push_back(run);
                    cur_lvl = IR;
                    run = 1;
                end
            end
            prev_busy = (busy === 1'b1);
        end
    end

    task automatic wait_done(input int max_cycles);
        bit seen = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge CLK);
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("wait_done_timeout", 0, 1);
        #1;
    endtask

    task automatic pulse_send(input logic [7:0] a, input logic [7:0] d, input logic rpt);
        address = a;
        data = d;
        repeat_code = rpt;
        send = 1'b1;
        @(negedge CLK);
        send = 1'b0;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       rpt;
        int         exp_busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        vecs[0] = '{8'h00, 8'h42, 1'b0, 484};
        vecs[1] = '{8'h00, 8'h00, 1'b1, 84};
        vecs[2] = '{8'hA5, 8'h3C, 1'b0, 484};
        vecs[3] = '{8'hFF, 8'h01, 1'b0, 484};
        vecs[4] = '{8'h12, 8'h34, 1'b1, 84};
        vecs[5] = '{8'h80, 8'h7F, 1'b0, 484};

        // Reset state
        repeat (3) @(negedge CLK);
        chk("reset_ir", int'(IR), 1);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        RST = 1'b0;
        @(negedge CLK);
        mon_en = 1'b1;
        chk("idle_ir", int'(IR), 1);

        // Table-driven frames
        foreach (vecs[k]) begin
            push_frame(vecs[k].a, vecs[k].d, vecs[k].rpt);
            pulse_send(vecs[k].a, vecs[k].d, vecs[k].rpt);
            wait_done(600);
            chk("tbl_busy_len", last_blen, vecs[k].exp_busy);
            repeat (3) @(negedge CLK);
            chk("tbl_idle_busy", int'(busy), 0);
            chk("tbl_idle_ir", int'(IR), 1);
        end

        // send re-pulsed and inputs changed mid-frame
        push_frame(8'h00, 8'h42, 1'b0);
        pulse_send(8'h00, 8'h42, 1'b0);
        repeat (100) @(negedge CLK);
        pulse_send(8'hFF, 8'h13, 1'b1);
        repeat (200) @(negedge CLK);
        address = 8'h5A;
        data = 8'hC3;
        pulse_send(8'h77, 8'h88, 1'b0);
        wait_done(600);
        repeat (10) @(negedge CLK);
        chk("no_queued_frame_busy", int'(busy), 0);

        // Reset during the bit-space of bit 10
        push_frame(8'h00, 8'h42, 1'b0);
        pulse_send(8'h00, 8'h42, 1'b0);
        repeat (200) @(negedge CLK);
        chk("pre_rst_busy", int'(busy), 1);
        chk("pre_rst_ir_space", int'(IR), 1);
        mon_en = 1'b0;
        drop_frame();
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_ir", int'(IR), 1);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("post_rst_busy", int'(busy), 0);
        mon_en = 1'b1;
        push_frame(8'h00, 8'h42, 1'b0);
        pulse_send(8'h00, 8'h42, 1'b0);
        wait_done(600);
        chk("post_rst_busy_len", last_blen, 484);

        // send held high across two frames
        push_frame(8'hAA, 8'h55, 1'b0);
        push_frame(8'hAA, 8'h55, 1'b0);
        address = 8'hAA;
        data = 8'h55;
        repeat_code = 1'b0;
        send = 1'b1;
        wait_done(600);
        chk("held_gap_ir", int'(IR), 1);
        chk("held_gap_busy", int'(busy), 0);
        @(negedge CLK);
        chk("held_restart_ir", int'(IR), 0);
        chk("held_restart_busy", int'(busy), 1);
        send = 1'b0;
        wait_done(600);
        repeat (5) @(negedge CLK);

        chk("done_count", done_cnt, frames_expected);
        chk("scoreboard_empty", exp_len_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
